// File: rtl/divider_unit_if.sv
// Handshake and result bundle between the CPU execute stage and divider_unit.
// Latency: none; wires only.
// Backpressure: the master issues with start and must hold off while busy is high; done pulses once.
interface divider_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] c;
  logic             is_zero;
  logic             is_negative;
  logic             div_by_zero;

  modport master (
    output start, a, b, op,
    input  busy, done, c, is_zero, is_negative, div_by_zero
  );

  modport slave (
    input  start, a, b, op,
    output busy, done, c, is_zero, is_negative, div_by_zero
  );
endinterface

// File: rtl/divider_unit.sv
// Multi-cycle restoring divider (one quotient bit per clock); DIVIDER_SIGNED_EN enables op[1] signed mode.
// Latency: done pulses WIDTH+3 cycles after the accepting edge (3 cycles when the divisor is zero).
// Backpressure: start is only sampled in IDLE; requests while busy or during done are dropped, not queued.
module divider_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           resetn,
  divider_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             op_rem_q;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] c_q;
  logic             is_zero_q;
  logic             is_negative_q;
  logic             div_by_zero_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             b_zero;

`ifdef DIVIDER_SIGNED_EN
  logic op_sgn_q;
  logic a_neg;
  logic b_neg;

  // Signs only matter for a signed op; magnitudes feed the unsigned core.
  assign a_neg = op_sgn_q & a_q[WIDTH-1];
  assign b_neg = op_sgn_q & b_q[WIDTH-1];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  // Truncating division: quotient sign is the XOR of operand signs, remainder follows the dividend.
  assign q_fix = (a_neg ^ b_neg) ? -quo : quo;
  assign r_fix = a_neg ? -rem : rem;
`else
  logic unused_op_sgn;

  assign unused_op_sgn = bus.op[1];
  assign a_mag = a_q;
  assign b_mag = b_q;
  assign q_fix = quo;
  assign r_fix = rem;
`endif

  // Restoring step: shift one dividend bit into the partial remainder and try the subtract one bit wider.
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs};

  // Divide by zero returns all-ones quotient and the untouched dividend as remainder.
  assign b_zero = (b_q == '0);
  assign res    = b_zero ? (op_rem_q ? a_q : '1) : (op_rem_q ? r_fix : q_fix);

  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.c           = c_q;
  assign bus.is_zero     = is_zero_q;
  assign bus.is_negative = is_negative_q;
  assign bus.div_by_zero = div_by_zero_q;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and status decode; busy covers PREP..FIXUP, done is the single DONE cycle.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nxt = PREP;
      PREP: begin
        busy      = 1'b1;
        state_nxt = b_zero ? FIXUP : ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (cnt == CW'(WIDTH - 1)) state_nxt = FIXUP;
      end
      FIXUP: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q           <= '0;
      b_q           <= '0;
      op_rem_q      <= 1'b0;
      dvs           <= '0;
      quo           <= '0;
      rem           <= '0;
      cnt           <= '0;
      c_q           <= '0;
      is_zero_q     <= 1'b0;
      is_negative_q <= 1'b0;
      div_by_zero_q <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      op_sgn_q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            op_rem_q <= bus.op[0];
`ifdef DIVIDER_SIGNED_EN
            op_sgn_q <= bus.op[1];
`endif
          end
        end
        PREP: begin
          dvs <= b_mag;
          quo <= a_mag;
          rem <= '0;
          cnt <= '0;
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        FIXUP: begin
          c_q           <= res;
          is_zero_q     <= (res == '0);
          is_negative_q <= res[WIDTH-1];
          div_by_zero_q <= b_zero;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_unit.sv
// Self-checking bench for divider_unit: directed cases, handshake corners, reset abort and random ops.
// Expected results come from plain-arithmetic division in the bench.
// Honours DIVIDER_SIGNED_EN the same way the design does.
module tb_divider_unit;
  localparam int W = 32;

  logic clk;
  logic resetn;
  int   n_vec;
  int   n_err;

  divider_unit_if #(.WIDTH(W)) dif ();

  divider_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: truncating division, with the divide-by-zero and overflow conventions.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop,
                                output logic [31:0] mc, output logic mdz);
    logic [31:0] q;
    logic [31:0] r;
    bit          sgn;
`ifdef DIVIDER_SIGNED_EN
    sgn = mop[1];
`else
    sgn = 1'b0;
`endif
    if (mb == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = ma;
    end else if (sgn) begin
      if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = 32'($signed(ma) / $signed(mb));
        r = 32'($signed(ma) % $signed(mb));
      end
    end else begin
      q = ma / mb;
      r = ma % mb;
    end
    mc  = mop[0] ? r : q;
    mdz = (mb == 32'd0);
  endfunction

  // Issue one op with a single-cycle start, scramble inputs after acceptance, wait for done (bounded).
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop, output int lat);
    @(negedge clk);
    dif.a     = ia;
    dif.b     = ib;
    dif.op    = iop;
    dif.start = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    dif.start = 1'b0;
    dif.a     = $urandom;
    dif.b     = $urandom;
    dif.op    = 2'($urandom);
    while (dif.done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    resetn    = 1'b0;
    dif.start = 1'b0;
    dif.a     = '0;
    dif.b     = '0;
    dif.op    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({dif.busy, dif.done, dif.is_zero, dif.is_negative, dif.div_by_zero} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=00000",
               {dif.busy, dif.done, dif.is_zero, dif.is_negative, dif.div_by_zero});
    end
    n_vec++;
    if (dif.c !== 32'd0) begin
      n_err++;
      $display("FAIL reset_c got=%h want=0", dif.c);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset busy=%b done=%b want 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_unsigned;
    int lat;
    run_op(32'd100, 32'd7, 2'b00, lat);
    n_vec++;
    if (lat != 35) begin
      n_err++;
      $display("FAIL uq_latency got=%0d want=35", lat);
    end
    n_vec++;
    if ({dif.c, dif.is_zero, dif.is_negative, dif.div_by_zero} !== {32'd14, 3'b000}) begin
      n_err++;
      $display("FAIL uq_result got c=%h z=%b n=%b dz=%b want c=0000000e 0 0 0",
               dif.c, dif.is_zero, dif.is_negative, dif.div_by_zero);
    end
    @(negedge clk);
    n_vec++;
    if (dif.done !== 1'b0 || dif.c !== 32'd14) begin
      n_err++;
      $display("FAIL done_pulse_hold done=%b c=%h want done=0 c=0000000e", dif.done, dif.c);
    end
    run_op(32'd100, 32'd7, 2'b01, lat);
    n_vec++;
    if (dif.c !== 32'd2) begin
      n_err++;
      $display("FAIL ur_result got=%h want=00000002", dif.c);
    end
    run_op(32'd5, 32'd9, 2'b00, lat);
    n_vec++;
    if (dif.c !== 32'd0 || dif.is_zero !== 1'b1) begin
      n_err++;
      $display("FAIL uq_zero got c=%h z=%b want c=0 z=1", dif.c, dif.is_zero);
    end
  endtask

  task automatic test_signed;
    int lat;
`ifdef DIVIDER_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, 2'b10, lat);
    n_vec++;
    if (dif.c !== 32'hFFFF_FFFD || dif.is_negative !== 1'b1) begin
      n_err++;
      $display("FAIL sq_neg got c=%h n=%b want c=fffffffd n=1", dif.c, dif.is_negative);
    end
    run_op(32'hFFFF_FFF9, 32'd2, 2'b11, lat);
    n_vec++;
    if (dif.c !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sr_neg got=%h want=ffffffff", dif.c);
    end
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, lat);
    n_vec++;
    if (dif.c !== 32'h8000_0000 || dif.div_by_zero !== 1'b0) begin
      n_err++;
      $display("FAIL s_overflow got c=%h dz=%b want c=80000000 dz=0", dif.c, dif.div_by_zero);
    end
`else
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 2'b10, lat);
    n_vec++;
    if (dif.c !== 32'd0 || dif.is_zero !== 1'b1) begin
      n_err++;
      $display("FAIL unsigned_forced got c=%h z=%b want c=0 z=1", dif.c, dif.is_zero);
    end
`endif
  endtask

  task automatic test_div_by_zero;
    int lat;
    run_op(32'h1234, 32'd0, 2'b00, lat);
    n_vec++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL dz_latency got=%0d want=3", lat);
    end
    n_vec++;
    if (dif.c !== 32'hFFFF_FFFF || dif.div_by_zero !== 1'b1 || dif.is_negative !== 1'b1) begin
      n_err++;
      $display("FAIL dz_quot got c=%h dz=%b n=%b want c=ffffffff dz=1 n=1", dif.c, dif.div_by_zero, dif.is_negative);
    end
    run_op(32'h1234, 32'd0, 2'b01, lat);
    n_vec++;
    if (dif.c !== 32'h1234 || dif.div_by_zero !== 1'b1) begin
      n_err++;
      $display("FAIL dz_rem got c=%h dz=%b want c=00001234 dz=1", dif.c, dif.div_by_zero);
    end
  endtask

  task automatic test_busy_ignore;
    int k;
    @(negedge clk);
    dif.a     = 32'd100;
    dif.b     = 32'd7;
    dif.op    = 2'b00;
    dif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (dif.busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_after_accept got=%b want=1", dif.busy);
    end
    dif.a = 32'd1000;
    dif.b = 32'd3;
    repeat (5) @(negedge clk);
    dif.start = 1'b0;
    k = 0;
    while (dif.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (dif.done !== 1'b1 || dif.c !== 32'd14) begin
      n_err++;
      $display("FAIL busy_ignore got done=%b c=%h want done=1 c=0000000e", dif.done, dif.c);
    end
    n_vec++;
    if (dif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_in_done got=%b want=0", dif.busy);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    dif.a     = 32'd100;
    dif.b     = 32'd7;
    dif.op    = 2'b00;
    dif.start = 1'b1;
    k = 0;
    while (dif.done !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (dif.done !== 1'b1 || dif.c !== 32'd14) begin
      n_err++;
      $display("FAIL b2b_first got done=%b c=%h want done=1 c=0000000e", dif.done, dif.c);
    end
    // start stays high through done; the new operands are taken once back in IDLE.
    dif.a = 32'd50;
    dif.b = 32'd5;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (dif.done !== 1'b1 && k < 100);
    dif.start = 1'b0;
    n_vec++;
    if (k != 36) begin
      n_err++;
      $display("FAIL b2b_spacing got=%0d want=36", k);
    end
    n_vec++;
    if (dif.c !== 32'd10) begin
      n_err++;
      $display("FAIL b2b_second got=%h want=0000000a", dif.c);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (dif.busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_third got busy=%b want=0", dif.busy);
    end
  endtask

  task automatic test_mid_reset;
    int  lat;
    bit  seen;
    @(negedge clk);
    dif.a     = 32'h0000_FFFF;
    dif.b     = 32'd3;
    dif.op    = 2'b00;
    dif.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    repeat (8) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    n_vec++;
    if ({dif.busy, dif.done, dif.is_zero, dif.is_negative, dif.div_by_zero} !== 5'b0 || dif.c !== 32'd0) begin
      n_err++;
      $display("FAIL midreset_outputs busy=%b done=%b c=%h z=%b n=%b dz=%b want all 0",
               dif.busy, dif.done, dif.c, dif.is_zero, dif.is_negative, dif.div_by_zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dif.done === 1'b1 || dif.busy === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_abort got activity=%b want=0", seen);
    end
    run_op(32'h0000_FFFF, 32'd3, 2'b00, lat);
    n_vec++;
    if (lat != 35 || dif.c !== 32'h0000_5555) begin
      n_err++;
      $display("FAIL midreset_fresh got lat=%0d c=%h want lat=35 c=00005555", lat, dif.c);
    end
  endtask

  task automatic test_random;
    int          lat;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  rop;
    logic [31:0] ec;
    logic        edz;
    for (int i = 0; i < 60; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rop = 2'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = 32'($urandom_range(1, 15));
        3:       ra = 32'h8000_0000;
        4:       rb = 32'hFFFF_FFFF;
        5:       ra = 32'($urandom_range(0, 20));
        default: ;
      endcase
      model(ra, rb, rop, ec, edz);
      run_op(ra, rb, rop, lat);
      n_vec++;
      if (dif.c !== ec) begin
        n_err++;
        $display("FAIL rnd_c a=%h b=%h op=%b got=%h want=%h", ra, rb, rop, dif.c, ec);
      end
      n_vec++;
      if (dif.is_zero !== (ec == 32'd0) || dif.is_negative !== ec[31]) begin
        n_err++;
        $display("FAIL rnd_flags a=%h b=%h op=%b got z=%b n=%b want z=%b n=%b",
                 ra, rb, rop, dif.is_zero, dif.is_negative, (ec == 32'd0), ec[31]);
      end
      n_vec++;
      if (dif.div_by_zero !== edz) begin
        n_err++;
        $display("FAIL rnd_dz a=%h b=%h got=%b want=%b", ra, rb, dif.div_by_zero, edz);
      end
      n_vec++;
      if (lat != (edz ? 3 : 35)) begin
        n_err++;
        $display("FAIL rnd_latency a=%h b=%h got=%0d want=%0d", ra, rb, lat, edz ? 3 : 35);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_by_zero();
    test_busy_ignore();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/divider_unit.md
Name: divider_unit

Overview:
- Multi-cycle 32-bit integer divider; the sequential counterpart to the combinational ALU multiplier path (division is the inverse of multiply).
- The CPU execute stage issues an operand pair plus an op select and pulses start. It stalls on busy, then captures c and the flags on done.
- Result and flag conventions match the ALU (c, is_zero, is_negative), so the CPU writeback path needs no special case.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and ≥ 4.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- resetn  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  dividend, captured when start accepted
- b  input  WIDTH  divisor, captured when start accepted
- op  input  2  op[0]: 0 = quotient, 1 = remainder; op[1]: 1 = signed (see Optional Feature)
- busy  output  1  high from the edge after acceptance until done asserts
- done  output  1  single-cycle pulse; c/flags valid
- c  output  WIDTH  selected result, held until next accepted start
- is_zero  output  1  c == 0, registered with c
- is_negative  output  1  c[WIDTH-1], registered with c
- div_by_zero  output  1  high with c when captured b == 0, held with c

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (resetn). resetn low at an edge forces IDLE and clears every output to 0: busy, done, c, is_zero, is_negative, div_by_zero. is_zero therefore resets to 0, not 1.
- State machine: IDLE, PREP, ITER, FIXUP, DONE.
- IDLE
  - start=1 at edge N → capture a, b, op; go to PREP.
  - start=0 → stay in IDLE; outputs hold.
- PREP (edge N+1)
  - Form the divisor/dividend magnitudes: absolute values if signed, else raw.
  - Clear the partial remainder; iteration counter = 0.
  - b == 0 → go to FIXUP and skip ITER; otherwise go to ITER.
- ITER (edges N+2 .. N+WIDTH+1, exactly WIDTH cycles)
  - Each cycle: shift {rem, quo} left one bit; trial = rem − divisor, computed at WIDTH+1 bits.
  - Trial non-negative → rem = trial and quo LSB = 1; otherwise restore rem.
  - Counter wraps from WIDTH−1 → go to FIXUP.
- FIXUP (edge N+WIDTH+2)
  - Signed op: quotient negated iff the operand signs differ; remainder takes the dividend's sign.
  - Register c per op[0], plus is_zero, is_negative, div_by_zero; done=1; go to DONE.
- DONE: done held for this one cycle only; next edge → IDLE, done=0.
- Latency: done asserts WIDTH+3 cycles after the accepting edge (35 for WIDTH=32). With b == 0 it is 3 cycles.
- busy: 1 in PREP, ITER and FIXUP; 0 in IDLE and DONE. start during busy or DONE is ignored, not queued.
- Back-to-back issue: start may be asserted in the cycle done is high. It is accepted on the following edge, once back in IDLE.
- Divide by zero: quotient = all ones; remainder = dividend (the original signed value); div_by_zero=1.
- Signed overflow, −2^(WIDTH−1) / −1: quotient wraps to 0x80000000 with remainder 0. No flag is raised.
- a, b and op may change freely after acceptance; only the captured copies are used.
- resetn low mid-operation aborts the operation; done never pulses for it.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined: op[1]=1 selects signed division with truncation toward zero; the magnitude and sign-fixup logic is compiled in.
- Undefined: op[1] is ignored and all operations are unsigned; the sign logic is absent. Latency is unchanged.

Test Plan:
- Unsigned quotient: a=100, b=7, op=00, start → done at cycle 35; c=14, is_zero=0, is_negative=0, div_by_zero=0.
- Unsigned remainder: a=100, b=7, op=01 → c=2. Then a=5, b=9, op=00 → c=0, is_zero=1.
- Signed (macro defined)
  - a=0xFFFFFFF9 (−7), b=2, op=10 → c=0xFFFFFFFD, is_negative=1.
  - Same operands, op=11 → c=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF, op=10 → c=0x80000000.
  - Macro undefined, a=0x80000000, b=0xFFFFFFFF, op=10 → c=0.
- Divide by zero: a=0x1234, b=0, op=00 → done at cycle 3, c=0xFFFFFFFF, div_by_zero=1. Same operands, op=01 → c=0x1234.
- Handshake
  - start re-pulsed with new operands while busy → ignored; result is still from the first operands.
  - start held high through done → second operation accepted on the edge after DONE.
- Reset: resetn=0 for one edge at cycle 10 of an operation → all outputs 0, done never pulses. A fresh start afterwards completes normally in 35 cycles.
